// File: rtl/gemm_tile_sequencer.sv
// Output-stationary GeMM tile-loop controller: walks (mt, nt, kt), drives A/B
// SRAM read addresses, MAC accumulate/clear strobes and the SRAM C write port.
module gemm_tile_sequencer #(
  parameter int unsigned AddrWidth     = 10,
  parameter int unsigned SizeAddrWidth = 8,
  parameter int unsigned TileM         = 4,
  parameter int unsigned TileK         = 4,
  parameter int unsigned TileN         = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o,
  output logic                     acc_en_o,
  output logic                     acc_clr_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCalc  = 3'd1;
  localparam logic [2:0] StRun   = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  // Products are formed wide enough to be exact, then truncated to AddrWidth.
  localparam int unsigned ProdWidth =
    (2 * SizeAddrWidth > AddrWidth) ? 2 * SizeAddrWidth : AddrWidth;
  localparam int unsigned CeilWidth = SizeAddrWidth + 1;

  function automatic logic [SizeAddrWidth-1:0] ceil_tiles(
    input logic [SizeAddrWidth-1:0] size,
    input int unsigned              tile
  );
    logic [CeilWidth-1:0] sum;
    sum = CeilWidth'(size) + CeilWidth'(tile - 1);
    return SizeAddrWidth'(sum / CeilWidth'(tile));
  endfunction

  logic [2:0]               state_q, state_d;
  logic [SizeAddrWidth-1:0] m_size_q, m_size_d;
  logic [SizeAddrWidth-1:0] k_size_q, k_size_d;
  logic [SizeAddrWidth-1:0] n_size_q, n_size_d;
  logic [SizeAddrWidth-1:0] mt_tiles_q, mt_tiles_d;
  logic [SizeAddrWidth-1:0] kt_tiles_q, kt_tiles_d;
  logic [SizeAddrWidth-1:0] nt_tiles_q, nt_tiles_d;
  logic [SizeAddrWidth-1:0] mt_q, mt_d;
  logic [SizeAddrWidth-1:0] nt_q, nt_d;
  logic [SizeAddrWidth-1:0] kt_q, kt_d;
  logic                     drain_q, drain_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_clr_q, s1_clr_d;
  logic                     s1_last_q, s1_last_d;
  logic [AddrWidth-1:0]     s1_c_addr_q, s1_c_addr_d;
  logic                     c_we_q, c_we_d;
  logic [AddrWidth-1:0]     c_addr_q, c_addr_d;

  logic                 issue;
  logic                 kt_last, nt_last, mt_last;
  logic [ProdWidth-1:0] a_prod, b_prod, c_prod;

  always_comb begin
    issue   = (state_q == StRun);
    kt_last = (kt_q == kt_tiles_q - SizeAddrWidth'(1));
    nt_last = (nt_q == nt_tiles_q - SizeAddrWidth'(1));
    mt_last = (mt_q == mt_tiles_q - SizeAddrWidth'(1));
    a_prod  = ProdWidth'(mt_q) * ProdWidth'(kt_tiles_q) + ProdWidth'(kt_q);
    b_prod  = ProdWidth'(kt_q) * ProdWidth'(nt_tiles_q) + ProdWidth'(nt_q);
    c_prod  = ProdWidth'(mt_q) * ProdWidth'(nt_tiles_q) + ProdWidth'(nt_q);
  end

  always_comb begin
    state_d    = state_q;
    m_size_d   = m_size_q;
    k_size_d   = k_size_q;
    n_size_d   = n_size_q;
    mt_tiles_d = mt_tiles_q;
    kt_tiles_d = kt_tiles_q;
    nt_tiles_d = nt_tiles_q;
    mt_d       = mt_q;
    nt_d       = nt_q;
    kt_d       = kt_q;
    drain_d    = drain_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StCalc;
          m_size_d = M_size_i;
          k_size_d = K_size_i;
          n_size_d = N_size_i;
        end
      end
      StCalc: begin
        mt_tiles_d = ceil_tiles(m_size_q, TileM);
        kt_tiles_d = ceil_tiles(k_size_q, TileK);
        nt_tiles_d = ceil_tiles(n_size_q, TileN);
        mt_d       = '0;
        nt_d       = '0;
        kt_d       = '0;
        drain_d    = 1'b0;
        if ((m_size_q == '0) || (k_size_q == '0) || (n_size_q == '0)) begin
          state_d = StDone;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!kt_last) begin
          kt_d = kt_q + SizeAddrWidth'(1);
        end else begin
          kt_d = '0;
          if (!nt_last) begin
            nt_d = nt_q + SizeAddrWidth'(1);
          end else begin
            nt_d = '0;
            if (!mt_last) begin
              mt_d = mt_q + SizeAddrWidth'(1);
            end else begin
              mt_d    = '0;
              state_d = StDrain;
            end
          end
        end
      end
      StDrain: begin
        // Two cycles: the final issue must clear stage 1 and stage 2.
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = StDone;
        end else begin
          drain_d = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s1_valid_d  = issue;
    s1_clr_d    = issue && (kt_q == '0);
    s1_last_d   = issue && kt_last;
    s1_c_addr_d = issue ? c_prod[AddrWidth-1:0] : '0;
    c_we_d      = s1_valid_q && s1_last_q;
    c_addr_d    = (s1_valid_q && s1_last_q) ? s1_c_addr_q : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      m_size_q    <= '0;
      k_size_q    <= '0;
      n_size_q    <= '0;
      mt_tiles_q  <= '0;
      kt_tiles_q  <= '0;
      nt_tiles_q  <= '0;
      mt_q        <= '0;
      nt_q        <= '0;
      kt_q        <= '0;
      drain_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_clr_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_c_addr_q <= '0;
      c_we_q      <= 1'b0;
      c_addr_q    <= '0;
    end else begin
      state_q     <= state_d;
      m_size_q    <= m_size_d;
      k_size_q    <= k_size_d;
      n_size_q    <= n_size_d;
      mt_tiles_q  <= mt_tiles_d;
      kt_tiles_q  <= kt_tiles_d;
      nt_tiles_q  <= nt_tiles_d;
      mt_q        <= mt_d;
      nt_q        <= nt_d;
      kt_q        <= kt_d;
      drain_q     <= drain_d;
      s1_valid_q  <= s1_valid_d;
      s1_clr_q    <= s1_clr_d;
      s1_last_q   <= s1_last_d;
      s1_c_addr_q <= s1_c_addr_d;
      c_we_q      <= c_we_d;
      c_addr_q    <= c_addr_d;
    end
  end

  always_comb begin
    sram_a_addr_o = issue ? a_prod[AddrWidth-1:0] : '0;
    sram_b_addr_o = issue ? b_prod[AddrWidth-1:0] : '0;
    sram_c_addr_o = c_addr_q;
    sram_c_we_o   = c_we_q;
    acc_en_o      = s1_valid_q;
    acc_clr_o     = s1_clr_q;
    busy_o        = (state_q != StIdle);
    done_o        = (state_q == StDone);
  end

endmodule
